// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, writeback source selects
// and load funct3 encodings.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the raw memory
// word, sign- or zero-extends it, and flags offsets that do not fit the access size.
module load_align
  import rv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then extension by load type; reserved funct3 codes act as LW.
  always_comb begin
    byte_v     = raw[7:0];
    half_v     = off[1] ? raw[31:16] : raw[15:0];
    data       = raw;
    misaligned = 1'b0;
    unique case (off)
      2'd0: byte_v = raw[7:0];
      2'd1: byte_v = raw[15:8];
      2'd2: byte_v = raw[23:16];
      2'd3: byte_v = raw[31:24];
    endcase
    case (funct3)
      FUNCT3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      FUNCT3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      FUNCT3_LH: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = off[0];
      end
      FUNCT3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = off[0];
      end
      default: begin
        data       = raw;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux. Drives the reg_file write port
// (also used as the decode forwarding source) and counts retired instructions.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic             mem_flush,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_we,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_imm,
  output logic             reg_wn,
  output logic [4:0]       addr_d,
  output logic [XLEN-1:0]  data_in,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);

  import rv_pkg::WB_SEL_ALU;
  import rv_pkg::WB_SEL_LOAD;
  import rv_pkg::WB_SEL_PC4;
  import rv_pkg::WB_SEL_IMM;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_reg_we;
  logic [1:0]      wb_sel;
  logic [2:0]      wb_funct3;
  logic [XLEN-1:0] wb_alu;
  logic [XLEN-1:0] wb_load;
  logic [XLEN-1:0] wb_pc;
  logic [XLEN-1:0] wb_imm;

  logic [XLEN-1:0] la_data;
  logic            la_mis;
  logic            retire;

  load_align u_load_align (
    .funct3     (wb_funct3),
    .off        (wb_alu[1:0]),
    .raw        (wb_load),
    .data       (la_data),
    .misaligned (la_mis)
  );

  // WB register: flush drops the incoming entry (fields left as they were),
  // stall holds everything, otherwise capture the MEM stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_reg_we <= 1'b0;
      wb_sel    <= '0;
      wb_funct3 <= '0;
      wb_alu    <= '0;
      wb_load   <= '0;
      wb_pc     <= '0;
      wb_imm    <= '0;
    end else if (mem_flush) begin
      wb_valid  <= 1'b0;
    end else if (!mem_stall) begin
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_reg_we <= mem_reg_we;
      wb_sel    <= mem_wb_sel;
      wb_funct3 <= mem_funct3;
      wb_alu    <= mem_alu_result;
      wb_load   <= mem_load_data;
      wb_pc     <= mem_pc;
      wb_imm    <= mem_imm;
    end
  end

  // An entry retires on the edge it leaves WB, so a long stall counts it once.
  assign retire = wb_valid && !misalign_err && (!mem_stall || mem_flush);

  // Retired-instruction counter; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Writeback source select, driven purely from the WB register.
  always_comb begin
    data_in = wb_alu;
    case (wb_sel)
      WB_SEL_ALU:  data_in = wb_alu;
      WB_SEL_LOAD: data_in = la_data;
      WB_SEL_PC4:  data_in = wb_pc + XLEN'(4);
      WB_SEL_IMM:  data_in = wb_imm;
      default:     data_in = wb_alu;
    endcase
  end

  assign misalign_err = wb_valid && (wb_sel == WB_SEL_LOAD) && la_mis;
  assign reg_wn       = wb_valid && wb_reg_we && (wb_rd != 5'd0) && !misalign_err;
  assign addr_d       = wb_rd;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a driver applies one MEM-stage beat per cycle and pushes
// the expected write-port state into a queue; a monitor compares after each edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_stall, mem_flush, mem_reg_we;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc, mem_imm;
  logic        reg_wn, misalign_err;
  logic [4:0]  addr_d;
  logic [31:0] data_in;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .mem_flush(mem_flush), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc(mem_pc), .mem_imm(mem_imm), .reg_wn(reg_wn), .addr_d(addr_d),
    .data_in(data_in), .misalign_err(misalign_err), .instret(instret)
  );

  typedef struct packed {
    logic        rst_n, valid, stall, flush;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, ld, pc, imm;
  } stim_t;

  typedef struct {
    bit          wn;
    bit          known;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          mis;
    logic [63:0] cnt;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_x;
  stim_t m_e;
  bit    m_valid;
  bit    m_known;
  logic [63:0] m_cnt;

  function automatic bit ref_mis(stim_t e);
    int off;
    off = int'(e.alu[1:0]);
    if (e.sel != 2'd1) return 1'b0;
    if (e.f3 == 3'd0 || e.f3 == 3'd4) return 1'b0;
    if (e.f3 == 3'd1 || e.f3 == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] ref_data(stim_t e);
    int off;
    logic [31:0] b, h;
    off = int'(e.alu[1:0]);
    b = (e.ld >> (8 * off)) & 32'hFF;
    h = (e.ld >> (16 * (off / 2))) & 32'hFFFF;
    case (e.sel)
      2'd0: return e.alu;
      2'd2: return e.pc + 32'd4;
      2'd3: return e.imm;
      default: begin
        case (e.f3)
          3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
          3'd4: return b;
          3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
          3'd5: return h;
          default: return e.ld;
        endcase
      end
    endcase
  endfunction

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic stim_t mk(bit v, logic [4:0] rd, bit we, logic [1:0] sel,
                               logic [2:0] f3, logic [31:0] alu, logic [31:0] ld,
                               logic [31:0] pc, logic [31:0] imm);
    stim_t s;
    s = '0;
    s.rst_n = 1'b1; s.valid = v; s.rd = rd; s.we = we; s.sel = sel; s.f3 = f3;
    s.alu = alu; s.ld = ld; s.pc = pc; s.imm = imm;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t x;
    bit   mis;
    @(negedge clk);
    rst_n = s.rst_n; mem_valid = s.valid; mem_stall = s.stall; mem_flush = s.flush;
    mem_rd = s.rd; mem_reg_we = s.we; mem_wb_sel = s.sel; mem_funct3 = s.f3;
    mem_alu_result = s.alu; mem_load_data = s.ld; mem_pc = s.pc; mem_imm = s.imm;
    if (!s.rst_n) begin
      m_valid = 1'b0; m_known = 1'b1; m_e = '0; m_cnt = '0;
    end else begin
      mis = m_valid && ref_mis(m_e);
      if (m_valid && !mis && (!s.stall || s.flush)) m_cnt = m_cnt + 64'd1;
      if (s.flush) begin
        m_valid = 1'b0; m_known = 1'b0;
      end else if (!s.stall) begin
        m_valid = s.valid; m_known = 1'b1; m_e = s;
      end
    end
    x.mis   = m_valid && ref_mis(m_e);
    x.wn    = m_valid && m_e.we && (m_e.rd != 5'd0) && !x.mis;
    x.known = m_known;
    x.addr  = m_e.rd;
    x.data  = ref_data(m_e);
    x.cnt   = m_cnt;
    q.push_back(x);
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the write port against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      cmp("sb_reg_wn", 64'(reg_wn), 64'(mon_x.wn));
      cmp("sb_misalign", 64'(misalign_err), 64'(mon_x.mis));
      cmp("sb_instret", instret, mon_x.cnt);
      if (mon_x.known) begin
        cmp("sb_addr_d", 64'(addr_d), 64'(mon_x.addr));
        cmp("sb_data_in", 64'(data_in), 64'(mon_x.data));
      end
    end
  end

  localparam logic [31:0] LDW = 32'h8081_7F80;

  initial begin
    stim_t s;
    rst_n = 1'b0; mem_valid = 1'b0; mem_stall = 1'b0; mem_flush = 1'b0;
    mem_rd = '0; mem_reg_we = 1'b0; mem_wb_sel = '0; mem_funct3 = '0;
    mem_alu_result = '0; mem_load_data = '0; mem_pc = '0; mem_imm = '0;
    m_valid = 1'b0; m_known = 1'b1; m_e = '0; m_cnt = '0;

    // reset held two cycles while MEM presents a valid writing instruction
    s = mk(1, 5'd3, 1, 2'd0, 3'd0, 32'h1111_1111, 0, 0, 0);
    s.rst_n = 1'b0;
    drive(s);
    drive(s);
    settle();
    cmp("rst_reg_wn", 64'(reg_wn), 64'd0);
    cmp("rst_data_in", 64'(data_in), 64'd0);
    cmp("rst_instret", instret, 64'd0);

    drive(mk(1, 5'd5, 1, 2'd0, 3'd0, 32'h1234_5678, 0, 0, 0));
    settle();
    cmp("alu_reg_wn", 64'(reg_wn), 64'd1);
    cmp("alu_addr_d", 64'(addr_d), 64'd5);
    cmp("alu_data", 64'(data_in), 64'h1234_5678);

    drive(mk(1, 5'd6, 1, 2'd1, 3'd0, 32'h0000_1000, LDW, 0, 0));
    settle();
    cmp("lb_data", 64'(data_in), 64'hFFFF_FF80);
    cmp("alu_retired", instret, 64'd1);

    drive(mk(1, 5'd6, 1, 2'd1, 3'd4, 32'h0000_1003, LDW, 0, 0));
    settle();
    cmp("lbu_data", 64'(data_in), 64'h0000_0080);

    drive(mk(1, 5'd6, 1, 2'd1, 3'd1, 32'h0000_1002, LDW, 0, 0));
    settle();
    cmp("lh_data", 64'(data_in), 64'hFFFF_8081);

    drive(mk(1, 5'd6, 1, 2'd1, 3'd5, 32'h0000_1001, LDW, 0, 0));
    settle();
    cmp("lhu_misalign", 64'(misalign_err), 64'd1);
    cmp("lhu_reg_wn", 64'(reg_wn), 64'd0);
    cmp("lhu_instret", instret, 64'd4);

    drive(mk(1, 5'd0, 1, 2'd0, 3'd0, 32'hDEAD_BEEF, 0, 0, 0));
    settle();
    cmp("rd0_reg_wn", 64'(reg_wn), 64'd0);
    cmp("misalign_not_counted", instret, 64'd4);

    drive(mk(1, 5'd7, 1, 2'd2, 3'd0, 0, 0, 32'hFFFF_FFFC, 0));
    settle();
    cmp("pc4_wrap", 64'(data_in), 64'd0);
    cmp("rd0_counted", instret, 64'd5);

    drive(mk(1, 5'd8, 1, 2'd3, 3'd0, 0, 0, 0, 32'hABCD_E000));
    settle();
    cmp("lui_data", 64'(data_in), 64'hABCD_E000);

    // stall three cycles on a valid entry while MEM shows other traffic
    drive(mk(1, 5'd9, 1, 2'd0, 3'd0, 32'hCAFE_0001, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      s = mk(1, 5'd12, 1, 2'd3, 3'd0, 0, 0, 0, $urandom);
      s.stall = 1'b1;
      drive(s);
      settle();
      cmp("stall_reg_wn", 64'(reg_wn), 64'd1);
      cmp("stall_data", 64'(data_in), 64'hCAFE_0001);
      cmp("stall_instret", instret, 64'd7);
    end
    drive(mk(1, 5'd10, 1, 2'd0, 3'd0, 32'h0000_00AA, 0, 0, 0));
    settle();
    cmp("stall_release_once", instret, 64'd8);

    // flush and stall together: incoming dropped, current entry still retires
    s = mk(1, 5'd11, 1, 2'd0, 3'd0, 32'h5555_5555, 0, 0, 0);
    s.stall = 1'b1; s.flush = 1'b1;
    drive(s);
    settle();
    cmp("flush_reg_wn", 64'(reg_wn), 64'd0);
    cmp("flush_prior_counted", instret, 64'd9);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s = mk($urandom_range(0, 9) != 0, 5'($urandom), 1'($urandom), 2'($urandom),
             3'($urandom), $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 15) == 0) s.pc = 32'hFFFF_FFFC;
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rst_n = ($urandom_range(0, 149) != 0);
      drive(s);
    end

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    settle();
    #2;
    cmp("sb_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
